// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings for the snake engine.
// Holds the direction codes, the pixel colour codes, the FSM state constants
// and the helper that returns the opposite of a direction.
package snake_pkg;

    // Direction encoding carried on dir_req and held in the engine
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Colour codes on draw_colour
    localparam logic [1:0] COL_ERASE = 2'b00;
    localparam logic [1:0] COL_BODY  = 2'b01;
    localparam logic [1:0] COL_HEAD  = 2'b11;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_INIT      = 3'd0;
    localparam state_t ST_IDLE      = 3'd1;
    localparam state_t ST_CALC      = 3'd2;
    localparam state_t ST_CHECK     = 3'd3;
    localparam state_t ST_DRAW_TAIL = 3'd4;
    localparam state_t ST_DRAW_BODY = 3'd5;
    localparam state_t ST_DRAW_HEAD = 3'd6;
    localparam state_t ST_DEAD      = 3'd7;

    // Up/down and left/right differ only in bit 0, so flipping it reverses
    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// snake_seg_ram: single-port segment store for the snake body.
// One address port shared by read and write; read data is registered
// (one-cycle latency). Contents are not reset: INIT rewrites every live entry.
module snake_seg_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 15,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Synchronous write and registered read on the shared address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/snake_engine.sv
// snake_engine: owns the snake body in a circular segment buffer, advances it
// on each accepted step, applies direction/growth/collision rules and streams
// erase/draw pixel beats over a valid/ready handshake.
// Optional build macro: SNAKE_WRAP_EN -- walls wrap around instead of killing.
module snake_engine
    import snake_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int GRID_X   = 160,
    parameter int GRID_Y   = 120,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 6,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           step,
    input  logic                           dir_valid,
    input  logic [1:0]                     dir_req,
    input  logic                           grow,
    input  logic                           restart,
    input  logic                           draw_ready,
    output logic                           draw_valid,
    output logic [X_W-1:0]                 draw_x,
    output logic [Y_W-1:0]                 draw_y,
    output logic [1:0]                     draw_colour,
    output logic                           busy,
    output logic                           game_over,
    output logic [$clog2(MAX_LEN+1)-1:0]   length
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int SEG_W = X_W + Y_W;

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // Control state
    state_t            state;
    logic              started;
    logic [PTR_W-1:0]  init_idx;
    logic [PTR_W-1:0]  head_ptr;
    logic [LEN_W-1:0]  length_q;
    logic [1:0]        dir;
    logic [1:0]        pend_dir;
    logic              pend_dir_vld;
    logic              pend_grow;
    logic              grow_now;
    logic [LEN_W-1:0]  chk_cnt;

    // Coordinate registers (no reset: always loaded before use)
    logic [X_W-1:0]    head_x, new_x, tail_x;
    logic [Y_W-1:0]    head_y, new_y, tail_y;

    // Combinational helpers
    logic [1:0]        eff_dir;
    logic [X_W-1:0]    calc_x;
    logic [Y_W-1:0]    calc_y;
    logic              wall_hit;
    logic              wall_dead;
    logic [Y_W-1:0]    init_y;
    logic              init_last;
    logic              init_beat_done;
    logic              chk_is_tail;
    logic              seg_hit;

    // RAM port
    logic              ram_we;
    logic [PTR_W-1:0]  ram_addr;
    logic [SEG_W-1:0]  ram_wdata;
    logic [SEG_W-1:0]  ram_rdata;

    snake_seg_ram #(
        .DEPTH (MAX_LEN),
        .W     (SEG_W),
        .AW    (PTR_W)
    ) u_seg_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // INIT lays the body out vertically below the start cell, tail first
    assign init_y         = Y_W'(START_Y + INIT_LEN - 1) - Y_W'(init_idx);
    assign init_last      = (init_idx == PTR_W'(INIT_LEN - 1));
    assign init_beat_done = (state == ST_INIT) && started && draw_ready;

    // The tail entry only blocks the head when the body is not moving off it
    assign chk_is_tail = (chk_cnt == length_q);
    assign seg_hit     = (ram_rdata == {new_x, new_y}) && (!chk_is_tail || grow_now);

    assign wall_dead = wall_hit && !WRAP_EN;

    // Next head position: commit pending direction unless it reverses, step one cell
    always_comb begin
        eff_dir = dir;
        if (pend_dir_vld && (pend_dir != reverse_of(dir))) begin
            eff_dir = pend_dir;
        end
        calc_x   = head_x;
        calc_y   = head_y;
        wall_hit = 1'b0;
        case (eff_dir)
            DIR_UP: begin
                if (head_y == '0) begin
                    wall_hit = 1'b1;
                    calc_y   = Y_W'(GRID_Y - 1);
                end else begin
                    calc_y = head_y - Y_W'(1);
                end
            end
            DIR_DOWN: begin
                if (head_y == Y_W'(GRID_Y - 1)) begin
                    wall_hit = 1'b1;
                    calc_y   = '0;
                end else begin
                    calc_y = head_y + Y_W'(1);
                end
            end
            DIR_LEFT: begin
                if (head_x == '0) begin
                    wall_hit = 1'b1;
                    calc_x   = X_W'(GRID_X - 1);
                end else begin
                    calc_x = head_x - X_W'(1);
                end
            end
            default: begin
                if (head_x == X_W'(GRID_X - 1)) begin
                    wall_hit = 1'b1;
                    calc_x   = '0;
                end else begin
                    calc_x = head_x + X_W'(1);
                end
            end
        endcase
    end

    // RAM address/write mux: INIT fill, CHECK walk from head back to tail, head write
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = head_ptr - PTR_W'(chk_cnt);
        ram_wdata = {new_x, new_y};
        case (state)
            ST_INIT: begin
                ram_addr  = init_idx;
                ram_wdata = {X_W'(START_X), init_y};
                ram_we    = started && draw_ready;
            end
            ST_DRAW_HEAD: begin
                ram_addr = head_ptr + PTR_W'(1);
                ram_we   = draw_ready;
            end
            default: ;
        endcase
    end

    // Pixel beat presented from state; held unchanged while the plotter stalls
    always_comb begin
        draw_valid  = 1'b0;
        draw_x      = '0;
        draw_y      = '0;
        draw_colour = COL_ERASE;
        case (state)
            ST_INIT: begin
                if (started) begin
                    draw_valid  = 1'b1;
                    draw_x      = X_W'(START_X);
                    draw_y      = init_y;
                    draw_colour = init_last ? COL_HEAD : COL_BODY;
                end
            end
            ST_DRAW_TAIL: begin
                draw_valid  = 1'b1;
                draw_x      = tail_x;
                draw_y      = tail_y;
                draw_colour = COL_ERASE;
            end
            ST_DRAW_BODY: begin
                draw_valid  = 1'b1;
                draw_x      = head_x;
                draw_y      = head_y;
                draw_colour = COL_BODY;
            end
            ST_DRAW_HEAD: begin
                draw_valid  = 1'b1;
                draw_x      = new_x;
                draw_y      = new_y;
                draw_colour = COL_HEAD;
            end
            default: ;
        endcase
    end

    assign busy      = started && (state != ST_IDLE) && (state != ST_DEAD);
    assign game_over = (state == ST_DEAD);
    assign length    = length_q;

    // Control FSM: pending requests, move sequencing, pointers and length
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_INIT;
            started      <= 1'b0;
            init_idx     <= '0;
            head_ptr     <= '0;
            length_q     <= '0;
            dir          <= DIR_UP;
            pend_dir     <= DIR_UP;
            pend_dir_vld <= 1'b0;
            pend_grow    <= 1'b0;
            grow_now     <= 1'b0;
            chk_cnt      <= '0;
        end else begin
            started <= 1'b1;

            if (dir_valid) begin
                pend_dir     <= dir_req;
                pend_dir_vld <= 1'b1;
            end else if (state == ST_CALC) begin
                pend_dir_vld <= 1'b0;
            end

            if (grow) begin
                pend_grow <= 1'b1;
            end else if (state == ST_CALC) begin
                pend_grow <= 1'b0;
            end

            case (state)
                ST_INIT: begin
                    if (init_beat_done) begin
                        if (init_last) begin
                            head_ptr <= PTR_W'(INIT_LEN - 1);
                            length_q <= LEN_W'(INIT_LEN);
                            dir      <= DIR_UP;
                            init_idx <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            init_idx <= init_idx + PTR_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (step) begin
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dir      <= eff_dir;
                    grow_now <= pend_grow && (length_q != LEN_W'(MAX_LEN));
                    chk_cnt  <= '0;
                    state    <= wall_dead ? ST_DEAD : ST_CHECK;
                end
                ST_CHECK: begin
                    // Read data lags the address by one cycle, so count 0 has nothing to compare
                    chk_cnt <= chk_cnt + LEN_W'(1);
                    if (chk_cnt != '0) begin
                        if (seg_hit) begin
                            state <= ST_DEAD;
                        end else if (chk_is_tail) begin
                            state <= grow_now ? ST_DRAW_BODY : ST_DRAW_TAIL;
                        end
                    end
                end
                ST_DRAW_TAIL: begin
                    if (draw_ready) begin
                        state <= ST_DRAW_BODY;
                    end
                end
                ST_DRAW_BODY: begin
                    if (draw_ready) begin
                        state <= ST_DRAW_HEAD;
                    end
                end
                ST_DRAW_HEAD: begin
                    if (draw_ready) begin
                        head_ptr <= head_ptr + PTR_W'(1);
                        if (grow_now) begin
                            length_q <= length_q + LEN_W'(1);
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    if (restart) begin
                        init_idx     <= '0;
                        pend_dir_vld <= 1'b0;
                        pend_grow    <= 1'b0;
                        state        <= ST_INIT;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Coordinate registers: current head, candidate head and captured tail
    always_ff @(posedge clk) begin
        if (init_beat_done && init_last) begin
            head_x <= X_W'(START_X);
            head_y <= Y_W'(START_Y);
        end else if ((state == ST_DRAW_HEAD) && draw_ready) begin
            head_x <= new_x;
            head_y <= new_y;
        end
        if (state == ST_CALC) begin
            new_x <= calc_x;
            new_y <= calc_y;
        end
        if ((state == ST_CHECK) && chk_is_tail) begin
            {tail_x, tail_y} <= ram_rdata;
        end
    end

endmodule
